bcd_to_bin_seq: RTL

Multi-cycle BCD-to-binary converter with start/done handshake. Accepts a packed multi-digit decimal (BCD) value and produces its binary equivalent by sequencing a shift-right/subtract-3 datapath (reverse double-dabble), one bit per clock. It sits between decimal entry logic (keypad or BCD counters) and binary arithmetic blocks, replacing the combinational divide-by-2 loop converters for widths where those are too large.

---
 rtl/bcd_to_bin_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Multi-cycle BCD-to-binary converter (reverse double-dabble). A packed
// multi-digit BCD value is captured on a start handshake. It is then shifted
// right one bit per clock through a combined {bcd, bin} register. After each
// shift, every BCD digit that is >= 8 is corrected by subtracting 3. After
// BIN_W shifts the binary field holds the converted value.
//
// Optional feature macro: BCD_TO_BIN_ERR_CHECK_EN
//   defined   : any digit > 9 at accept goes straight to DONE with
//               bin_out = 0 and err = 1 (no shifts).
//   undefined : no digit check; err is tied to 0 and invalid digits run
//               through the normal datapath.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   conversion request, sampled only while ready = 1
//   bcd_in   in   packed BCD input, digit 0 in bits [3:0]
//   ready    out  high in IDLE only
//   busy     out  high while shifting
//   done     out  one-cycle pulse; bin_out/err valid from this cycle
//   bin_out  out  converted value, held until the next done
//   err      out  input contained a digit > 9 (check build only)
// -----------------------------------------------------------------------------
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_bin;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [SR_W-1:0]  w_shifted;
  logic [SR_W-1:0]  w_sr_next;
  logic             w_last_shift;

  // Shift right with zero fill, then correct every BCD digit in parallel.
  // A digit >= 8 after the shift is exactly one with its MSB set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_shifted = r_sr >> 1;
    w_sr_next = w_shifted;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_shifted[BIN_W + 4*d + 3]) begin
        w_sr_next[BIN_W + 4*d +: 4] = w_shifted[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  assign w_last_shift = (r_cnt == CNT_W'(BIN_W - 1));

`ifdef BCD_TO_BIN_ERR_CHECK_EN
  logic r_err;
  logic w_bad_digit;

  always_comb begin
    w_bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        w_bad_digit = 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Single FSM process; ready/busy/done are registered alongside the state
  // so no input has a combinational path to an output.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // The shift register is cleared too, so a discarded conversion
      // leaves no residue behind.
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
`ifdef BCD_TO_BIN_ERR_CHECK_EN
            if (w_bad_digit) begin
              r_state <= S_DONE;
              r_bin   <= '0;
              r_err   <= 1'b1;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end else
`endif
            begin
              r_state <= S_SHIFT;
              r_sr    <= {bcd_in, {BIN_W{1'b0}}};
              r_cnt   <= '0;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          // start is deliberately ignored here: no request queuing.
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last_shift) begin
            r_state <= S_DONE;
            r_bin   <= w_sr_next[BIN_W-1:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
            r_err   <= 1'b0;
`endif
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign bin_out = r_bin;

endmodule
